gshare_branch_predictor: RTL and testbench
==========================================

Name: gshare_branch_predictor

Overview:
- Next-generation conditional branch direction predictor for the IF stage. Replaces the per-PC local-history table with a gshare organisation: a global history register (GHR) XORed with PC bits indexes a table of parametrised-width saturating counters.
- The GHR is updated speculatively at prediction time. It is repaired from a snapshot that travels with the branch through the pipeline and returns at resolve time.

Parameters:
- INDEX_WIDTH, 10, log2 of pattern history table (PHT) entries; PC bits [INDEX_WIDTH+1:2] form the index.
- GHR_WIDTH, 8, global history length; must be 1..INDEX_WIDTH.
- CTR_WIDTH, 2, saturating counter width; must be >= 1.
- CTR_INIT, 1, counter reset value; must be < 2**CTR_WIDTH.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, all state holds.
- now_pc  input  32  fetch PC to predict.
- pred_fire  input  1  fetch consumes this cycle's prediction for a conditional branch; shift GHR speculatively.
- jump  output  1  predicted taken.
- pred_ghr  output  GHR_WIDTH  GHR value used for this prediction; carried with the instruction.
- update_control  input  1  a conditional branch resolved this cycle.
- update_pc  input  32  PC of the resolved branch.
- update_ghr  input  GHR_WIDTH  pred_ghr snapshot returned with the resolved branch.
- update_jump  input  1  actual outcome, 1 = taken.
- update_mispredict  input  1  resolved direction differs from the prediction; valid only with update_control.

Behaviour:
- Lookup (combinational):
  - idx = now_pc[INDEX_WIDTH+1:2] XOR zero-extended GHR.
  - jump = MSB of PHT[idx].
  - pred_ghr = current GHR.
  - Valid in every cycle, including when rdy_in is low.
- Update (registered, when update_control && rdy_in):
  - uidx = update_pc[INDEX_WIDTH+1:2] XOR zero-extended update_ghr.
  - PHT[uidx] increments if update_jump, decrements otherwise.
  - Saturates at 2**CTR_WIDTH-1 and at 0; no wrap.
- GHR next-state (when rdy_in):
  - Priority 1: update_control && update_mispredict: GHR <= {update_ghr[GHR_WIDTH-2:0], update_jump}. Recovery; any same-cycle pred_fire shift is discarded.
  - Priority 2: pred_fire: GHR <= {GHR[GHR_WIDTH-2:0], jump}.
  - Otherwise GHR holds.
  - A correct-prediction update never touches the GHR.
  - GHR_WIDTH = 1: the shift reduces to GHR <= new bit.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update counter (read-before-write). The new value is visible the next cycle.
- rdy_in low: PHT and GHR hold; update_control and pred_fire are ignored.
- Reset (rst_in low, asynchronous, any cycle including mid-update):
  - GHR <= 0; every PHT entry <= CTR_INIT.
  - Outputs while reset is asserted: jump = MSB of CTR_INIT, pred_ghr = 0.
  - State is usable on the first rising edge after rst_in deasserts.
- Latency: prediction 0 cycles; an update is visible to lookups 1 cycle later.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, two extra output ports are present:
  - stat_branches, 32-bit: counts accepted update_control.
  - stat_mispredicts, 32-bit: counts accepted update_control && update_mispredict.
- Both counters reset to 0 asynchronously, hold when rdy_in is low, and wrap modulo 2**32.
- When undefined, the ports and counters do not exist and core behaviour is identical.

Test Plan:
- Reset, defaults (INDEX_WIDTH=10, GHR_WIDTH=8, CTR_WIDTH=2, CTR_INIT=1): any now_pc -> jump=0, pred_ghr=0.
- Saturation: two taken updates, pc=0x100, ghr=0 -> the third cycle lookup of pc=0x100 with GHR=0 gives jump=1. After six further taken updates the counter is 3. Then one not-taken -> counter 2, jump still 1. Two more not-taken -> jump=0.
- Speculative shift: pred_fire for 3 cycles with jump=1,0,1 from GHR=0 -> GHR=8'b00000101, and pred_ghr tracks each step.
- Recovery priority: GHR=0x5A, same cycle pred_fire=1 and update_control=1, update_mispredict=1, update_ghr=0x03, update_jump=1 -> next GHR=0x07, not a shifted 0x5A.
- Read-before-write and rdy_in: update and lookup on the same idx in one cycle -> old counter MSB that cycle, new the next. With rdy_in=0, update and pred_fire produce no state change.
- Async reset mid-stream: assert rst_in low between clock edges after training -> GHR and outputs return to reset values immediately. With BP_STATS_EN, after 5 updates with 2 mispredicts -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
// gshare conditional branch direction predictor: GHR XOR PC indexes a table of saturating counters.
// Optional macro BP_STATS_EN adds resolved-branch and mispredict counters as outputs.
module gshare_branch_predictor #(
  parameter int INDEX_WIDTH = 10,
  parameter int GHR_WIDTH   = 8,
  parameter int CTR_WIDTH   = 2,
  parameter int CTR_INIT    = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [31:0]          now_pc,
  input  logic                 pred_fire,
  output logic                 jump,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic                 update_control,
  input  logic [31:0]          update_pc,
  input  logic [GHR_WIDTH-1:0] update_ghr,
  input  logic                 update_jump,
  input  logic                 update_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  localparam int Entries = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CtrMax  = '1;
  localparam logic [CTR_WIDTH-1:0] CtrInit = CTR_WIDTH'(CTR_INIT);

  logic [GHR_WIDTH-1:0]   ghr_q;
  logic [GHR_WIDTH-1:0]   ghr_d;
  logic [CTR_WIDTH-1:0]   pht_q [Entries];
  logic [INDEX_WIDTH-1:0] idx;
  logic [INDEX_WIDTH-1:0] uidx;
  logic [CTR_WIDTH-1:0]   uctr;
  logic [CTR_WIDTH-1:0]   uctr_d;
  logic [GHR_WIDTH-1:0]   ghrShift;
  logic [GHR_WIDTH-1:0]   ghrRecover;
  logic                   unused_pc_bits;

  assign idx      = now_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
  assign jump     = pht_q[idx][CTR_WIDTH-1];
  assign pred_ghr = ghr_q;

  assign uidx = update_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(update_ghr);
  assign uctr = pht_q[uidx];

  assign unused_pc_bits = ^{now_pc[31:INDEX_WIDTH+2], now_pc[1:0],
                            update_pc[31:INDEX_WIDTH+2], update_pc[1:0]};

  // A one-bit history has nothing to shift: the new outcome simply replaces it.
  generate
    if (GHR_WIDTH == 1) begin : g_ghr_one
      assign ghrShift   = jump;
      assign ghrRecover = update_jump;
    end else begin : g_ghr_wide
      assign ghrShift   = {ghr_q[GHR_WIDTH-2:0], jump};
      assign ghrRecover = {update_ghr[GHR_WIDTH-2:0], update_jump};
    end
  endgenerate

  always_comb begin
    uctr_d = uctr;
    if (update_jump) begin
      if (uctr != CtrMax) uctr_d = uctr + 1'b1;
    end else if (uctr != '0) begin
      uctr_d = uctr - 1'b1;
    end
  end

  // Mispredict recovery overrides any speculative shift issued in the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (update_control && update_mispredict) ghr_d = ghrRecover;
    else if (pred_fire)                      ghr_d = ghrShift;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     ghr_q <= '0;
    else if (rdy_in) ghr_q <= ghr_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < Entries; i++) pht_q[i] <= CtrInit;
    end else if (rdy_in && update_control) begin
      pht_q[uidx] <= uctr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (rdy_in && update_control) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (update_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor against an array-based reference model.
// Honours BP_STATS_EN when the design is built with it.
module tb_gshare_branch_predictor;

  localparam int Entries = 1024;
  localparam int CtrMax  = 3;
  localparam int CtrInit = 1;
  localparam int TakenAt = 2;
  localparam int GhrMask = 255;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] now_pc;
  logic        pred_fire;
  logic        jump;
  logic [7:0]  pred_ghr;
  logic        update_control;
  logic [31:0] update_pc;
  logic [7:0]  update_ghr;
  logic        update_jump;
  logic        update_mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pht [Entries];
  int ghr;
  int statB;
  int statM;

  always #5 clk_in = ~clk_in;

  gshare_branch_predictor dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .now_pc           (now_pc),
    .pred_fire        (pred_fire),
    .jump             (jump),
    .pred_ghr         (pred_ghr),
    .update_control   (update_control),
    .update_pc        (update_pc),
    .update_ghr       (update_ghr),
    .update_jump      (update_jump),
    .update_mispredict(update_mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelIdx(input logic [31:0] pc, input int g);
    return int'((pc >> 2) & 32'd1023) ^ g;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < Entries; i++) pht[i] = CtrInit;
    ghr   = 0;
    statB = 0;
    statM = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic fire, input logic uc,
                               input logic [31:0] upc, input logic [7:0] ughr,
                               input logic uj, input logic um);
    now_pc            = pc;
    pred_fire         = fire;
    update_control    = uc;
    update_pc         = upc;
    update_ghr        = ughr;
    update_jump       = uj;
    update_mispredict = um;
  endtask

  // Check this cycle's lookup against the model, then advance the model across the edge.
  task automatic stepCycle(input string tag);
    int expJ;
    int u;
    #3;
    expJ = (pht[modelIdx(now_pc, ghr)] >= TakenAt) ? 1 : 0;
    checkOutput({tag, "_jump"}, {31'b0, jump}, expJ);
    checkOutput({tag, "_ghr"}, {24'b0, pred_ghr}, ghr);
`ifdef BP_STATS_EN
    checkOutput({tag, "_statb"}, stat_branches, statB);
    checkOutput({tag, "_statm"}, stat_mispredicts, statM);
`endif
    @(posedge clk_in);
    if (rdy_in) begin
      if (update_control) begin
        u = modelIdx(update_pc, int'(update_ghr));
        if (update_jump) pht[u] = (pht[u] < CtrMax) ? pht[u] + 1 : CtrMax;
        else             pht[u] = (pht[u] > 0) ? pht[u] - 1 : 0;
        statB++;
        if (update_mispredict) statM++;
      end
      if (update_control && update_mispredict) ghr = ((int'(update_ghr) << 1) | int'(update_jump)) & GhrMask;
      else if (pred_fire)                      ghr = ((ghr << 1) | expJ) & GhrMask;
    end
    #1;
  endtask

  initial begin
    resetModel();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);

    // Outputs while reset is held.
    #2;
    for (int i = 0; i < 3; i++) begin
      now_pc = $urandom();
      #1;
      checkOutput("reset_jump", {31'b0, jump}, 32'd0);
      checkOutput("reset_ghr", {24'b0, pred_ghr}, 32'd0);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Saturation at pc 0x100, ghr 0.
    applyStimulus(32'h100, 1'b0, 1'b1, 32'h100, 8'h0, 1'b1, 1'b0);
    stepCycle("sat_up0");
    stepCycle("sat_up1");
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h100, 8'h0, 1'b1, 1'b0);
    #3;
    checkOutput("sat_after2", {31'b0, jump}, 32'd1);
    #1;
    stepCycle("sat_look");
    applyStimulus(32'h100, 1'b0, 1'b1, 32'h100, 8'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) stepCycle("sat_more");
    applyStimulus(32'h100, 1'b0, 1'b1, 32'h100, 8'h0, 1'b0, 1'b0);
    stepCycle("sat_dn0");
    checkOutput("sat_ctr2", {31'b0, jump}, 32'd1);
    stepCycle("sat_dn1");
    stepCycle("sat_dn2");
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h100, 8'h0, 1'b0, 1'b0);
    #3;
    checkOutput("sat_low", {31'b0, jump}, 32'd0);
    #1;

    // Train entries so speculative fire sees taken, not-taken, taken.
    applyStimulus(32'h0, 1'b0, 1'b1, 32'h200, 8'h0, 1'b1, 1'b0);
    stepCycle("train_a0");
    stepCycle("train_a1");
    applyStimulus(32'h0, 1'b0, 1'b1, 32'h200, 8'h2, 1'b1, 1'b0);
    stepCycle("train_b0");
    stepCycle("train_b1");
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    stepCycle("spec0");
    applyStimulus(32'h300, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    stepCycle("spec1");
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    stepCycle("spec2");
    checkOutput("spec_final", {24'b0, pred_ghr}, 32'h05);

    // Recovery: reach 0x5A, then mispredict overrides a same-cycle fire.
    applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 8'h2D, 1'b0, 1'b1);
    stepCycle("rec_set");
    checkOutput("rec_5a", {24'b0, pred_ghr}, 32'h5A);
    applyStimulus(32'h7C0, 1'b1, 1'b1, 32'h40, 8'h03, 1'b1, 1'b1);
    stepCycle("rec_prio");
    checkOutput("rec_07", {24'b0, pred_ghr}, 32'h07);

    // Read-before-write on index 0x107.
    applyStimulus(32'h400, 1'b0, 1'b1, 32'h400, 8'h07, 1'b1, 1'b0);
    #3;
    checkOutput("rbw_old", {31'b0, jump}, 32'd0);
    #1;
    stepCycle("rbw_upd");
    applyStimulus(32'h400, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    #3;
    checkOutput("rbw_new", {31'b0, jump}, 32'd1);
    #1;

    // rdy_in low freezes all state.
    rdy_in = 1'b0;
    applyStimulus(32'h400, 1'b1, 1'b1, 32'h400, 8'h07, 1'b0, 1'b1);
    stepCycle("hold0");
    stepCycle("hold1");
    rdy_in = 1'b1;
    applyStimulus(32'h400, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    stepCycle("hold_after");
    checkOutput("hold_ghr", {24'b0, pred_ghr}, 32'h07);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      applyStimulus($urandom() & 32'hFFFF_F03F, 1'(($urandom_range(0, 1))),
                    1'($urandom_range(0, 2) != 0), $urandom() & 32'hFFFF_F03F,
                    8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0));
      stepCycle("rand");
    end
    rdy_in = 1'b1;

    // Asynchronous reset between edges.
    #3;
    applyStimulus(32'h200, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    rst_in = 1'b0;
    #1;
    checkOutput("areset_ghr", {24'b0, pred_ghr}, 32'd0);
    checkOutput("areset_jump", {31'b0, jump}, 32'd0);
    now_pc = 32'h100;
    #1;
    checkOutput("areset_jump2", {31'b0, jump}, 32'd0);
    resetModel();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Five resolves with two mispredicts after reset.
    applyStimulus(32'h0, 1'b0, 1'b1, 32'h500, 8'h0, 1'b1, 1'b0);
    stepCycle("st0");
    stepCycle("st1");
    update_mispredict = 1'b1;
    stepCycle("st2");
    update_mispredict = 1'b0;
    stepCycle("st3");
    update_mispredict = 1'b1;
    stepCycle("st4");
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    stepCycle("st_idle");
`ifdef BP_STATS_EN
    checkOutput("stat_b5", stat_branches, 32'd5);
    checkOutput("stat_m2", stat_mispredicts, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
